control_sequencer: RTL

- Hardwired Mini SRC control unit. It steps each instruction through fetch and execute phases (T0..T7).
- It drives the datapath's bus-drive, register-load, memory and ALU control lines from the current step and the IR contents.
- It is the generating end of the datapath's control interface: the datapath consumes these strobes, and this block produces them.

---
 rtl/minisrc_pkg.sv | 79 +++++++
 rtl/control_sequencer_if.sv | 28 ++
 rtl/control_sequencer_step_decode.sv | 77 +++++++
 rtl/control_sequencer.sv | 84 ++++++++
 4 files changed

// File: rtl/minisrc_pkg.sv
// Shared definitions for the Mini SRC hardwired control unit:
// opcodes, step encoding, IR field positions and the strobe bundle.
package minisrc_pkg;

    // Opcode position inside the instruction register.
    localparam int OPC_MSB = 31;
    localparam int OPC_LSB = 27;

    typedef logic [OPC_MSB-OPC_LSB:0] opcode_t;

    localparam opcode_t OP_LD   = 5'b00000;
    localparam opcode_t OP_LDI  = 5'b00001;
    localparam opcode_t OP_ST   = 5'b00010;
    localparam opcode_t OP_ADD  = 5'b00011;
    localparam opcode_t OP_ROL  = 5'b01011;
    localparam opcode_t OP_ADDI = 5'b01100;
    localparam opcode_t OP_ORI  = 5'b01110;
    localparam opcode_t OP_MUL  = 5'b01111;
    localparam opcode_t OP_DIV  = 5'b10000;
    localparam opcode_t OP_NEG  = 5'b10001;
    localparam opcode_t OP_NOT  = 5'b10010;
    localparam opcode_t OP_BR   = 5'b10011;
    localparam opcode_t OP_JR   = 5'b10100;
    localparam opcode_t OP_MFHI = 5'b11000;
    localparam opcode_t OP_MFLO = 5'b11001;
    localparam opcode_t OP_NOP  = 5'b11010;
    localparam opcode_t OP_HALT = 5'b11011;

    // ALU code used for effective-address and branch-target arithmetic.
    localparam opcode_t ALU_ADD = 5'b00011;

    typedef enum logic [3:0] {
        S_RST, T0, T1, T2, T3, T4, T5, T6, T7, S_HALT
    } state_t;

    // Instructions grouped by the shape of their execute sequence.
    typedef enum logic [3:0] {
        CL_LD, CL_LDI, CL_ST, CL_RTYPE, CL_IMM, CL_MULDIV, CL_UNARY,
        CL_BR, CL_JR, CL_MFHI, CL_MFLO, CL_HALT, CL_NOP
    } op_class_t;

    typedef struct packed {
        logic    run;
        logic    PCout, MDRout, ZMuxOut, HIout, LOout, Cout, BAout, Rout;
        logic    PCin, IncPC, MARin, MDRin, IRin, Yin, HIin, LOin, Rin, CONin;
        logic    Gra, Grb, Grc;
        logic    read, write, RAMenable;
        logic    ALUin, ZMuxEnable, ZSelect;
        opcode_t aluControl;
    } ctrl_t;

    function automatic op_class_t classify(opcode_t op);
        if (op == OP_LD)                         return CL_LD;
        else if (op == OP_LDI)                   return CL_LDI;
        else if (op == OP_ST)                    return CL_ST;
        else if (op >= OP_ADD  && op <= OP_ROL)  return CL_RTYPE;
        else if (op >= OP_ADDI && op <= OP_ORI)  return CL_IMM;
        else if (op == OP_MUL  || op == OP_DIV)  return CL_MULDIV;
        else if (op == OP_NEG  || op == OP_NOT)  return CL_UNARY;
        else if (op == OP_BR)                    return CL_BR;
        else if (op == OP_JR)                    return CL_JR;
        else if (op == OP_MFHI)                  return CL_MFHI;
        else if (op == OP_MFLO)                  return CL_MFLO;
        else if (op == OP_HALT)                  return CL_HALT;
        else                                     return CL_NOP;
    endfunction

    // Final execute step of each class; the step after it is T0.
    function automatic state_t last_step(op_class_t cls);
        case (cls)
            CL_LD, CL_ST:               return T7;
            CL_LDI, CL_RTYPE, CL_IMM:   return T5;
            CL_MULDIV, CL_BR:           return T6;
            CL_UNARY:                   return T4;
            default:                    return T3;
        endcase
    endfunction

endpackage

// File: rtl/control_sequencer_if.sv
// Control interface between the sequencer (master) and the datapath (slave).
interface control_sequencer_if;
    logic [31:0] ir;
    logic        con_ff;
    logic        run;
    logic        PCout, MDRout, ZMuxOut, HIout, LOout, Cout, BAout, Rout;
    logic        PCin, IncPC, MARin, MDRin, IRin, Yin, HIin, LOin, Rin, CONin;
    logic        Gra, Grb, Grc;
    logic        read, write, RAMenable;
    logic        ALUin, ZMuxEnable, ZSelect;
    logic [4:0]  aluControl;

    modport master (
        input  ir, con_ff,
        output run, PCout, MDRout, ZMuxOut, HIout, LOout, Cout, BAout, Rout,
               PCin, IncPC, MARin, MDRin, IRin, Yin, HIin, LOin, Rin, CONin,
               Gra, Grb, Grc, read, write, RAMenable,
               ALUin, ZMuxEnable, ZSelect, aluControl
    );

    modport slave (
        output ir, con_ff,
        input  run, PCout, MDRout, ZMuxOut, HIout, LOout, Cout, BAout, Rout,
               PCin, IncPC, MARin, MDRin, IRin, Yin, HIin, LOin, Rin, CONin,
               Gra, Grb, Grc, read, write, RAMenable,
               ALUin, ZMuxEnable, ZSelect, aluControl
    );
endinterface

// File: rtl/control_sequencer_step_decode.sv
// Moore decode of (step, opcode, branch condition) into the strobe bundle.
module step_decode
    import minisrc_pkg::*;
(
    input  state_t  state,
    input  opcode_t op,
    input  logic    con_ff,
    output ctrl_t   ctrl
);
    op_class_t cls;
    assign cls = classify(op);

    // Strobes for the current step; fetch ignores the opcode.
    always_comb begin
        // NOTE: everything defaults first, so no branch can leave an output held (no latch).
        ctrl     = '0;
        ctrl.run = 1'b1;
        case (state)
            T0: begin ctrl.PCout = 1'b1; ctrl.MARin = 1'b1; ctrl.IncPC = 1'b1; end
            T1: begin ctrl.read = 1'b1; ctrl.RAMenable = 1'b1; ctrl.MDRin = 1'b1; end
            T2: begin ctrl.MDRout = 1'b1; ctrl.IRin = 1'b1; end
            T3: case (cls)
                CL_LD, CL_LDI, CL_ST: begin ctrl.Grb = 1'b1; ctrl.BAout = 1'b1; ctrl.Yin = 1'b1; end
                CL_RTYPE, CL_IMM:     begin ctrl.Grb = 1'b1; ctrl.Rout = 1'b1; ctrl.Yin = 1'b1; end
                CL_MULDIV:            begin ctrl.Gra = 1'b1; ctrl.Rout = 1'b1; ctrl.Yin = 1'b1; end
                CL_UNARY: begin
                    ctrl.Grb = 1'b1; ctrl.Rout = 1'b1; ctrl.ALUin = 1'b1; ctrl.aluControl = op;
                end
                CL_BR:   begin ctrl.Grb = 1'b1; ctrl.Rout = 1'b1; ctrl.CONin = 1'b1; end
                CL_JR:   begin ctrl.Gra = 1'b1; ctrl.Rout = 1'b1; ctrl.PCin = 1'b1; end
                CL_MFHI: begin ctrl.HIout = 1'b1; ctrl.Gra = 1'b1; ctrl.Rin = 1'b1; end
                CL_MFLO: begin ctrl.LOout = 1'b1; ctrl.Gra = 1'b1; ctrl.Rin = 1'b1; end
                default: ;
            endcase
            T4: case (cls)
                CL_LD, CL_LDI, CL_ST: begin ctrl.Cout = 1'b1; ctrl.ALUin = 1'b1; ctrl.aluControl = ALU_ADD; end
                CL_RTYPE: begin
                    ctrl.Grc = 1'b1; ctrl.Rout = 1'b1; ctrl.ALUin = 1'b1; ctrl.aluControl = op;
                end
                CL_IMM: begin ctrl.Cout = 1'b1; ctrl.ALUin = 1'b1; ctrl.aluControl = op; end
                CL_MULDIV: begin
                    ctrl.Grb = 1'b1; ctrl.Rout = 1'b1; ctrl.ALUin = 1'b1; ctrl.aluControl = op;
                end
                CL_UNARY: begin
                    ctrl.ZMuxEnable = 1'b1; ctrl.ZMuxOut = 1'b1; ctrl.Gra = 1'b1; ctrl.Rin = 1'b1;
                end
                CL_BR:   begin ctrl.PCout = 1'b1; ctrl.Yin = 1'b1; end
                default: ;
            endcase
            T5: case (cls)
                CL_LD, CL_ST: begin ctrl.ZMuxEnable = 1'b1; ctrl.ZMuxOut = 1'b1; ctrl.MARin = 1'b1; end
                CL_LDI, CL_RTYPE, CL_IMM: begin
                    ctrl.ZMuxEnable = 1'b1; ctrl.ZMuxOut = 1'b1; ctrl.Gra = 1'b1; ctrl.Rin = 1'b1;
                end
                CL_MULDIV: begin ctrl.ZMuxEnable = 1'b1; ctrl.ZMuxOut = 1'b1; ctrl.LOin = 1'b1; end
                CL_BR:     begin ctrl.Cout = 1'b1; ctrl.ALUin = 1'b1; ctrl.aluControl = ALU_ADD; end
                default: ;
            endcase
            T6: case (cls)
                CL_LD: begin ctrl.read = 1'b1; ctrl.RAMenable = 1'b1; ctrl.MDRin = 1'b1; end
                CL_ST: begin ctrl.Gra = 1'b1; ctrl.Rout = 1'b1; ctrl.MDRin = 1'b1; end
                CL_MULDIV: begin
                    ctrl.ZMuxEnable = 1'b1; ctrl.ZSelect = 1'b1; ctrl.ZMuxOut = 1'b1; ctrl.HIin = 1'b1;
                end
                CL_BR: begin ctrl.ZMuxEnable = 1'b1; ctrl.ZMuxOut = 1'b1; ctrl.PCin = con_ff; end
                default: ;
            endcase
            T7: case (cls)
                CL_LD:   begin ctrl.MDRout = 1'b1; ctrl.Gra = 1'b1; ctrl.Rin = 1'b1; end
                CL_ST:   begin ctrl.write = 1'b1; ctrl.RAMenable = 1'b1; end
                default: ;
            endcase
            S_HALT:  ctrl.run = 1'b0;
            default: ;
        endcase
    end
endmodule

// File: rtl/control_sequencer.sv
// Mini SRC hardwired control unit: step register, next-step logic and
// the strobe decoder driving the datapath control interface.
module control_sequencer
    import minisrc_pkg::*;
#(
    parameter int OPC_W = 5,
    parameter int IR_W  = 32
) (
    input  logic                 clock,
    input  logic                 clear,
    control_sequencer_if.master  bus
);
    state_t    state_q, state_d;
    opcode_t   op;
    op_class_t cls;
    ctrl_t     ctrl;
    logic      ir_unused;

    assign op        = bus.ir[IR_W-1 -: OPC_W];
    assign cls       = classify(op);
    assign ir_unused = ^bus.ir[IR_W-OPC_W-1:0];

    // Step register; clear wins over every transition, even mid-instruction.
    always_ff @(posedge clock) begin
        // NOTE: <= so the register samples values from before the edge.
        if (clear) state_q <= S_RST;
        else       state_q <= state_d;
    end

    // Next step: fetch runs straight through, execute ends at the class's last step.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_RST:  state_d = T0;
            T0:     state_d = T1;
            T1:     state_d = T2;
            T2:     state_d = T3;
            T3, T4, T5, T6, T7: begin
                if (state_q == T3 && cls == CL_HALT) state_d = S_HALT;
                else if (state_q == last_step(cls))  state_d = T0;
                else                                 state_d = state_t'(state_q + 4'd1);
            end
            S_HALT:  state_d = S_HALT;
            default: state_d = S_RST;
        endcase
    end

    step_decode u_step_decode (
        .state  (state_q),
        .op     (op),
        .con_ff (bus.con_ff),
        .ctrl   (ctrl)
    );

    assign bus.run        = ctrl.run;
    assign bus.PCout      = ctrl.PCout;
    assign bus.MDRout     = ctrl.MDRout;
    assign bus.ZMuxOut    = ctrl.ZMuxOut;
    assign bus.HIout      = ctrl.HIout;
    assign bus.LOout      = ctrl.LOout;
    assign bus.Cout       = ctrl.Cout;
    assign bus.BAout      = ctrl.BAout;
    assign bus.Rout       = ctrl.Rout;
    assign bus.PCin       = ctrl.PCin;
    assign bus.IncPC      = ctrl.IncPC;
    assign bus.MARin      = ctrl.MARin;
    assign bus.MDRin      = ctrl.MDRin;
    assign bus.IRin       = ctrl.IRin;
    assign bus.Yin        = ctrl.Yin;
    assign bus.HIin       = ctrl.HIin;
    assign bus.LOin       = ctrl.LOin;
    assign bus.Rin        = ctrl.Rin;
    assign bus.CONin      = ctrl.CONin;
    assign bus.Gra        = ctrl.Gra;
    assign bus.Grb        = ctrl.Grb;
    assign bus.Grc        = ctrl.Grc;
    assign bus.read       = ctrl.read;
    assign bus.write      = ctrl.write;
    assign bus.RAMenable  = ctrl.RAMenable;
    assign bus.ALUin      = ctrl.ALUin;
    assign bus.ZMuxEnable = ctrl.ZMuxEnable;
    assign bus.ZSelect    = ctrl.ZSelect;
    assign bus.aluControl = ctrl.aluControl;
endmodule
